// File: rtl/score_overlay_writer_if.sv
// Glyph ROM read port and overlay RAM write port of the score overlay writer.
// master: drives rom_addr/wr_*, reads rom_data. slave: the memory side.
interface score_overlay_writer_if #(
    parameter int ROM_AW = 16,
    parameter int RAM_AW = 15
);
    logic [ROM_AW-1:0] rom_addr;
    logic [8:0]        rom_data;
    logic              wr_en;
    logic [RAM_AW-1:0] wr_addr;
    logic [8:0]        wr_data;

    modport master (
        output rom_addr,
        input  rom_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/score_overlay_writer.sv
// Copies score digit glyphs from the glyph ROM into a 4-slot overlay RAM,
// writing only during vblank.
// Ports: clk25/reset, four score digits, vblank, busy, slot_done,
// bus (master): rom_addr/rom_data, wr_en/wr_addr/wr_data.
module score_overlay_writer #(
    parameter int GLYPH_W   = 55,
    parameter int GLYPH_H   = 75,
    parameter int GLYPH_PIX = GLYPH_W * GLYPH_H,
    parameter int ROM_AW    = 16,
    parameter int RAM_AW    = 15
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic [3:0] score_1_tens,
    input  logic [3:0] score_1_ones,
    input  logic [3:0] score_2_tens,
    input  logic [3:0] score_2_ones,
    input  logic       vblank,
    output logic       busy,
    output logic       slot_done,
    score_overlay_writer_if.master bus
);
    typedef enum logic [1:0] {IDLE, COPY, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [3:0]  shadow_q [4];
    logic [3:0]  score_w  [4];
    logic [1:0]  cur_slot_q;
    logic [3:0]  cur_digit_q;
    logic [12:0] p_q;
    logic        busy_q, done_q;
    logic        wr_en_q, blank_q;
    logic [RAM_AW-1:0] wr_addr_q;

    logic        hit;
    logic [1:0]  hit_slot;
    logic        last_p;
    logic        issue;
    logic        blank_dig;
    logic [ROM_AW-1:0] rom_addr_d;
    logic [RAM_AW-1:0] wr_addr_d;

    assign score_w[0] = score_1_tens;
    assign score_w[1] = score_1_ones;
    assign score_w[2] = score_2_tens;
    assign score_w[3] = score_2_ones;

    // Lowest-numbered mismatching slot wins.
    always_comb begin
        hit      = 1'b0;
        hit_slot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (score_w[i] != shadow_q[i]) begin
                hit      = 1'b1;
                hit_slot = 2'(i);
            end
        end
    end

    assign last_p    = (p_q == 13'(GLYPH_PIX - 1));
    assign blank_dig = (cur_digit_q > 4'd9);

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hit) state_d = COPY;
            COPY:    if (vblank && last_p) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Blank digits never reach the ROM multiplier, so the product fits.
    always_comb begin
        issue      = (state_q == COPY) && vblank;
        rom_addr_d = '0;
        if (state_q == COPY && !blank_dig) begin
            rom_addr_d = ROM_AW'(cur_digit_q) * ROM_AW'(GLYPH_PIX)
                       + ROM_AW'(p_q);
        end
        wr_addr_d = RAM_AW'(cur_slot_q) * RAM_AW'(GLYPH_PIX)
                  + RAM_AW'(p_q);
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            shadow_q    <= '{default: 4'hF};
            cur_slot_q  <= 2'd0;
            cur_digit_q <= 4'd0;
            p_q         <= 13'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            blank_q     <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= issue;
            blank_q <= blank_dig;
            if (issue) begin
                wr_addr_q <= wr_addr_d;
                p_q       <= p_q + 13'd1;
            end
            if (state_q == IDLE && hit) begin
                cur_slot_q  <= hit_slot;
                cur_digit_q <= score_w[hit_slot];
                p_q         <= 13'd0;
                busy_q      <= 1'b1;
            end
            // Shadow takes the snapshot, so a mid-copy change recopies.
            if (state_q == DRAIN) begin
                shadow_q[cur_slot_q] <= cur_digit_q;
                done_q               <= 1'b1;
                busy_q               <= 1'b0;
            end
        end
    end

    assign bus.rom_addr = rom_addr_d;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = blank_q ? 9'd0 : bus.rom_data;
    assign busy         = busy_q;
    assign slot_done    = done_q;
endmodule

// File: tb/tb_score_overlay_writer.sv
// Randomized bench for score_overlay_writer with a glyph ROM model,
// a shadow copy of the overlay RAM and a write-sequence scoreboard.
module tb_score_overlay_writer;
    localparam int PIX = 4125;

    logic       clk25 = 1'b0;
    logic       reset;
    logic       vblank;
    logic [3:0] sc [4];
    logic       busy, slot_done;

    always #20 clk25 = ~clk25;

    score_overlay_writer_if bus ();

    score_overlay_writer dut (
        .clk25       (clk25),
        .reset       (reset),
        .score_1_tens(sc[0]),
        .score_1_ones(sc[1]),
        .score_2_tens(sc[2]),
        .score_2_ones(sc[3]),
        .vblank      (vblank),
        .busy        (busy),
        .slot_done   (slot_done),
        .bus         (bus)
    );

    function automatic logic [8:0] rom_f(int a);
        return 9'((a * 37 + (a >> 4)) ^ (a >> 9));
    endfunction

    function automatic logic [8:0] exp_pix(int d, int i);
        if (d > 9) return 9'd0;
        return rom_f(d * PIX + i);
    endfunction

    always @(posedge clk25) bus.rom_data <= rom_f(int'(bus.rom_addr));

    logic [8:0] mem [16500];
    int   n_wr = 0, n_done = 0, copy_cnt = 0, base = 0;
    int   seq_err = 0, vb_err = 0;
    logic vb_last = 1'b0;
    int   slots_q[$];

    always @(negedge clk25) begin
        vb_last <= vblank;
        if (reset) begin
            copy_cnt <= 0;
        end else begin
            if (bus.wr_en) begin
                n_wr <= n_wr + 1;
                mem[bus.wr_addr] <= bus.wr_data;
                if (!vb_last) vb_err <= vb_err + 1;
                if (copy_cnt == 0) begin
                    if (int'(bus.wr_addr) % PIX != 0) seq_err <= seq_err + 1;
                    base <= int'(bus.wr_addr);
                end else if (int'(bus.wr_addr) != base + copy_cnt) begin
                    seq_err <= seq_err + 1;
                end
                copy_cnt <= copy_cnt + 1;
            end
            if (slot_done) begin
                n_done <= n_done + 1;
                slots_q.push_back(base / PIX);
                if (copy_cnt != PIX) seq_err <= seq_err + 1;
                copy_cnt <= 0;
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int slot_errs(int s, int d);
        int e = 0;
        for (int i = 0; i < PIX; i++)
            if (mem[s * PIX + i] !== exp_pix(d, i)) e++;
        return e;
    endfunction

    function automatic int ram_errs();
        int e = 0;
        for (int s = 0; s < 4; s++) e += slot_errs(s, int'(sc[s]));
        return e;
    endfunction

    function automatic int order(int from);
        int c = 0;
        for (int i = from; i < slots_q.size(); i++) c = c * 4 + slots_q[i];
        return c;
    endfunction

    task automatic settle(input bit rnd_vb, output int lo, output int hi);
        int idle = 0;
        int cyc = 0;
        lo = 1 << 30;
        hi = -1;
        while (idle < 3 && cyc < 30000) begin
            vblank = rnd_vb ? ($urandom_range(3, 0) != 0) : 1'b1;
            @(negedge clk25);
            if (busy && bus.rom_addr != 0) begin
                if (int'(bus.rom_addr) < lo) lo = int'(bus.rom_addr);
                if (int'(bus.rom_addr) > hi) hi = int'(bus.rom_addr);
            end
            idle = busy ? 0 : idle + 1;
            @(posedge clk25);
            #1;
            cyc++;
        end
        vblank = 1'b1;
        check("settle_in_time", int'(cyc < 30000), 1);
    endtask

    task automatic wait_cnt(int n);
        int cyc = 0;
        while (copy_cnt < n && cyc < 10000) begin
            @(posedge clk25);
            #1;
            cyc++;
        end
        check("reach_copy_cnt", int'(cyc < 10000), 1);
    endtask

    int w0, d0, q0, lo, hi, cyc, stall_wr;

    initial begin
        reset  = 1'b1;
        vblank = 1'b1;
        for (int i = 0; i < 4; i++) sc[i] = 4'd0;
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_slot_done", int'(slot_done), 0);
        check("rst_rom_addr", int'(bus.rom_addr), 0);

        // full refresh after reset
        @(posedge clk25);
        #1;
        w0 = n_wr; d0 = n_done; q0 = slots_q.size();
        reset = 1'b0;
        settle(1'b0, lo, hi);
        check("init_writes", n_wr - w0, 4 * PIX);
        check("init_done", n_done - d0, 4);
        check("init_order", order(q0), 27);
        check("init_ram", ram_errs(), 0);
        check("init_busy", int'(busy), 0);

        // single digit change 3->4 on slot 3
        sc[3] = 4'd3;
        settle(1'b0, lo, hi);
        w0 = n_wr; d0 = n_done; q0 = slots_q.size();
        sc[3] = 4'd4;
        settle(1'b0, lo, hi);
        check("s3_writes", n_wr - w0, PIX);
        check("s3_done", n_done - d0, 1);
        check("s3_order", order(q0), 3);
        check("s3_rom_lo", lo, 4 * PIX);
        check("s3_rom_hi", hi, 5 * PIX - 1);
        check("s3_ram", ram_errs(), 0);

        // vblank stall in the middle of a copy
        w0 = n_wr; d0 = n_done;
        sc[1] = 4'd5;
        wait_cnt(2000);
        vblank   = 1'b0;
        stall_wr = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk25);
            if (i > 0 && bus.wr_en) stall_wr++;
            @(posedge clk25);
            #1;
        end
        check("stall_no_wr", stall_wr, 0);
        vblank = 1'b1;
        settle(1'b0, lo, hi);
        check("stall_writes", n_wr - w0, PIX);
        check("stall_done", n_done - d0, 1);
        check("stall_seq", seq_err, 0);
        check("stall_ram", ram_errs(), 0);

        // score changes while its slot is being copied
        w0 = n_wr; d0 = n_done; q0 = slots_q.size();
        sc[0] = 4'd1;
        wait_cnt(1000);
        sc[0] = 4'd2;
        cyc = 0;
        while (n_done == d0 && cyc < 10000) begin
            @(posedge clk25);
            #1;
            cyc++;
        end
        check("stale_first_done", int'(cyc < 10000), 1);
        check("stale_first_glyph", slot_errs(0, 1), 0);
        settle(1'b0, lo, hi);
        check("stale_writes", n_wr - w0, 2 * PIX);
        check("stale_done", n_done - d0, 2);
        check("stale_order", order(q0), 0);
        check("stale_ram", ram_errs(), 0);

        // out-of-range digit blanks the slot
        w0 = n_wr;
        sc[1] = 4'hC;
        settle(1'b0, lo, hi);
        check("blank_writes", n_wr - w0, PIX);
        check("blank_slot", slot_errs(1, 12), 0);
        check("blank_ram", ram_errs(), 0);

        // reset in the middle of a copy
        sc[2] = 4'd7;
        wait_cnt(3000);
        #4;
        check("pre_rst_wr_en", int'(bus.wr_en), 1);
        reset = 1'b1;
        #1;
        check("async_rst_wr_en", int'(bus.wr_en), 0);
        check("async_rst_busy", int'(busy), 0);
        repeat (3) @(posedge clk25);
        #1;
        w0 = n_wr; d0 = n_done; q0 = slots_q.size();
        reset = 1'b0;
        settle(1'b0, lo, hi);
        check("rerst_writes", n_wr - w0, 4 * PIX);
        check("rerst_done", n_done - d0, 4);
        check("rerst_order", order(q0), 27);
        check("rerst_ram", ram_errs(), 0);

        // random digit changes with random vblank gaps
        for (int k = 0; k < 2; k++) begin
            int s;
            logic [3:0] d;
            s = $urandom_range(3, 0);
            d = 4'($urandom_range(15, 0));
            while (d == sc[s]) d = 4'($urandom_range(15, 0));
            w0 = n_wr; d0 = n_done; q0 = slots_q.size();
            sc[s] = d;
            settle(1'b1, lo, hi);
            check("rnd_writes", n_wr - w0, PIX);
            check("rnd_done", n_done - d0, 1);
            check("rnd_order", order(q0), s);
            check("rnd_ram", ram_errs(), 0);
        end

        check("seq_errors", seq_err, 0);
        check("vblank_errors", vb_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
